instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
//   MIPS-subset instruction decoder for the decode (D) stage of the pipelined CPU.
//   Maps the opcode and function fields of the D-stage instruction to one-hot instruction flags.
//   The flags are combinational; the D-stage controller uses them in the same cycle.
//   Also provides class summaries, an illegal-instruction flag, registered copies and a sticky error flag.
// PARAMETERS
//   none
// PORTS
//   clk          in   1   system clock; only clock, all registers on rising edge
//   reset        in   1   synchronous, active-high reset
//   op           in   6   instruction[31:26]
//   func         in   6   instruction[5:0]; ignored unless op==6'b000000
//   addu,subu    out  1   combinational flags for R-type ADDU / SUBU
//   ori,lui      out  1   combinational flags for ORI / LUI
//   lw,sw        out  1   combinational flags for LW / SW
//   beq          out  1   combinational flag for BEQ
//   j,jal,jr     out  1   combinational flags for J / JAL / JR
//   reg_write    out  1   comb: addu|subu|ori|lui|lw|jal
//   mem_access   out  1   comb: lw|sw
//   jump_any     out  1   comb: beq|j|jal|jr
//   illegal      out  1   comb: no flag set
//   dec_q        out  10  registered {addu,subu,ori,lui,lw,sw,beq,j,jal,jr}, MSB=addu
//   illegal_seen out  1   sticky registered flag: some cycle decoded illegal
// BEHAVIOUR
//   Encodings (binary), exact match on every listed bit:
//     addu: op=000000, func=100001   subu: op=000000, func=100011
//     jr:   op=000000, func=001000   ori:  op=001101   lui: op=001111
//     lw:   op=100011   sw: op=101011   beq: op=000100   j: op=000010   jal: op=000011
//   - For non-zero op, func is don't-care. For op=000000, any other func leaves all flags 0.
//   - At most one flag is high at any time (one-hot or all-zero); no X on outputs for known inputs.
//   - Combinational outputs respond within the same cycle, with no clock dependency, including during reset.
//   - dec_q latches the 10 flags on every rising clk edge: latency 1 cycle.
//   - illegal_seen is set on any clk edge where illegal=1; it holds until reset.
//   - Reset (sync, sampled at clk edge): dec_q=0 and illegal_seen=0.
//     Reset wins over a simultaneous illegal decode.
//   - Reset asserted mid-stream clears the registers at the next edge only.
//     The combinational flags are unaffected by reset.
//   - Register contents power up undefined until the first reset edge.
//   - All-zero instruction (op=0, func=0, i.e. sll/nop) is illegal.
// TESTING
//   - op=000000, func=100001 -> addu=1, others 0, reg_write=1; next edge dec_q=10'b1000000000.
//   - op=000000, func=001000 -> jr=1, jump_any=1, reg_write=0.
//   - op=000000, func=100011 -> subu=1; op=100011 (func=100011) -> lw=1, subu=0, mem_access=1.
//   - op=000011 -> jal=1, reg_write=1; op=000010 -> j=1, reg_write=0; op=000100 -> beq=1.
//   - op=000000, func=000000 -> illegal=1; next edge illegal_seen=1; it stays 1 with legal ops.
//     After a reset edge it is 0 and dec_q=0.
//   - Sweep all 64 op values x all 64 func values -> exactly the listed encodings assert flags, and flags are one-hot.

Source files
------------

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
//   Decode-stage instruction decoder for a MIPS subset. The opcode and
//   function fields of the D-stage instruction are turned into one-hot
//   instruction flags, which the D-stage controller uses in the same cycle.
//   Class summaries and an illegal flag are derived from the flags. A
//   registered copy of the flags and a sticky illegal flag are also kept.
//
// Ports
//   clk           in   1   system clock, all registers on rising edge
//   reset         in   1   synchronous, active-high reset (registers only)
//   op            in   6   instruction[31:26]
//   func          in   6   instruction[5:0], only used when op == 6'b000000
//   addu, subu    out  1   R-type ADDU / SUBU
//   ori, lui      out  1   ORI / LUI
//   lw, sw        out  1   LW / SW
//   beq           out  1   BEQ
//   j, jal, jr    out  1   J / JAL / JR
//   reg_write     out  1   addu|subu|ori|lui|lw|jal
//   mem_access    out  1   lw|sw
//   jump_any      out  1   beq|j|jal|jr
//   illegal       out  1   no instruction flag set
//   dec_q         out  10  registered {addu,subu,ori,lui,lw,sw,beq,j,jal,jr}
//   illegal_seen  out  1   sticky: an illegal decode was clocked since reset
//
// There is no handshake: the decoder is purely combinational plus two
// unconditionally clocked registers.
// ---------------------------------------------------------------------------
module instr_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       addu,
  output logic       subu,
  output logic       ori,
  output logic       lui,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       j,
  output logic       jal,
  output logic       jr,
  output logic       reg_write,
  output logic       mem_access,
  output logic       jump_any,
  output logic       illegal,
  output logic [9:0] dec_q,
  output logic       illegal_seen
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [9:0] w_flags;
  logic [9:0] r_dec_q;
  logic       r_illegal_seen;

  // Each branch sets at most one bit, so the vector is one-hot or zero.
  // func only matters inside the R-type branch.
  always_comb begin
    w_flags = 10'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: w_flags[9] = 1'b1;
          FN_SUBU: w_flags[8] = 1'b1;
          FN_JR:   w_flags[0] = 1'b1;
          default: w_flags    = 10'b0;
        endcase
      end
      OP_ORI:  w_flags[7] = 1'b1;
      OP_LUI:  w_flags[6] = 1'b1;
      OP_LW:   w_flags[5] = 1'b1;
      OP_SW:   w_flags[4] = 1'b1;
      OP_BEQ:  w_flags[3] = 1'b1;
      OP_J:    w_flags[2] = 1'b1;
      OP_JAL:  w_flags[1] = 1'b1;
      default: w_flags    = 10'b0;
    endcase
  end

  assign {addu, subu, ori, lui, lw, sw, beq, j, jal, jr} = w_flags;

  assign reg_write  = addu | subu | ori | lui | lw | jal;
  assign mem_access = lw | sw;
  assign jump_any   = beq | j | jal | jr;
  assign illegal    = ~(|w_flags);

  // Reset takes priority, so an illegal decode in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_q        <= 10'b0;
      r_illegal_seen <= 1'b0;
    end else begin
      r_dec_q <= w_flags;
      if (illegal) begin
        r_illegal_seen <= 1'b1;
      end
    end
  end

  assign dec_q        = r_dec_q;
  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_instr_decoder.sv
// ---------------------------------------------------------------------------
// tb_instr_decoder
//   Self-checking bench for instr_decoder. Inputs are driven on the falling
//   edge, combinational outputs are checked 1 ns later against a reference
//   table, and the expected register contents are queued and compared 1 ns
//   after the next rising edge.
// ---------------------------------------------------------------------------
module tb_instr_decoder;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       addu, subu, ori, lui, lw, sw, beq, j, jal, jr;
  logic       reg_write, mem_access, jump_any, illegal;
  logic [9:0] dec_q;
  logic       illegal_seen;

  logic [9:0] exp_q[$];
  logic       seen_q[$];
  logic       exp_seen;

  int n_total;
  int n_bad;

  instr_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .func         (func),
    .addu         (addu),
    .subu         (subu),
    .ori          (ori),
    .lui          (lui),
    .lw           (lw),
    .sw           (sw),
    .beq          (beq),
    .j            (j),
    .jal          (jal),
    .jr           (jr),
    .reg_write    (reg_write),
    .mem_access   (mem_access),
    .jump_any     (jump_any),
    .illegal      (illegal),
    .dec_q        (dec_q),
    .illegal_seen (illegal_seen)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (op=%b func=%b t=%0t)",
               tag, got, exp, op, func, $time);
    end
  endtask

  // Reference encoding table, bit order {addu,subu,ori,lui,lw,sw,beq,j,jal,jr}.
  function automatic logic [9:0] ref_flags(input logic [5:0] o,
                                           input logic [5:0] f);
    logic [9:0] r;
    r = 10'b0;
    if (o == 6'b000000 && f == 6'b100001) r = 10'b1000000000;
    if (o == 6'b000000 && f == 6'b100011) r = 10'b0100000000;
    if (o == 6'b001101)                   r = 10'b0010000000;
    if (o == 6'b001111)                   r = 10'b0001000000;
    if (o == 6'b100011)                   r = 10'b0000100000;
    if (o == 6'b101011)                   r = 10'b0000010000;
    if (o == 6'b000100)                   r = 10'b0000001000;
    if (o == 6'b000010)                   r = 10'b0000000100;
    if (o == 6'b000011)                   r = 10'b0000000010;
    if (o == 6'b000000 && f == 6'b001000) r = 10'b0000000001;
    return r;
  endfunction

  // driver: one cycle of stimulus, comb checks, then register checks
  task automatic step(input logic [5:0] o, input logic [5:0] f,
                      input logic rst);
    logic [9:0] ef;
    logic [9:0] got;
    @(negedge clk);
    op    = o;
    func  = f;
    reset = rst;
    #1;
    ef  = ref_flags(o, f);
    got = {addu, subu, ori, lui, lw, sw, beq, j, jal, jr};
    check_val("flags", {6'b0, got}, {6'b0, ef});
    check_val("onehot", {15'b0, ($countones(got) <= 1)}, 16'h1);
    check_val("reg_write", {15'b0, reg_write},
              {15'b0, ef[9] | ef[8] | ef[7] | ef[6] | ef[5] | ef[1]});
    check_val("mem_access", {15'b0, mem_access}, {15'b0, ef[5] | ef[4]});
    check_val("jump_any", {15'b0, jump_any},
              {15'b0, ef[3] | ef[2] | ef[1] | ef[0]});
    check_val("illegal", {15'b0, illegal}, {15'b0, (ef == 10'b0)});

    if (rst) exp_seen = 1'b0;
    else if (ef == 10'b0) exp_seen = 1'b1;
    exp_q.push_back(rst ? 10'b0 : ef);
    seen_q.push_back(exp_seen);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0 || seen_q.size() == 0) begin
      check_val("queue_empty", 16'h0, 16'h1);
    end else begin
      check_val("dec_q", {6'b0, dec_q}, {6'b0, exp_q.pop_front()});
      check_val("illegal_seen", {15'b0, illegal_seen},
                {15'b0, seen_q.pop_front()});
    end
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    exp_seen = 1'b0;
    reset    = 1'b1;
    op       = 6'b0;
    func     = 6'b0;

    // reset state (comb flags still live during reset)
    step(6'b000000, 6'b100001, 1'b1);
    step(6'b001101, 6'b000000, 1'b1);

    // directed cases
    step(6'b000000, 6'b100001, 1'b0);  // addu
    step(6'b000000, 6'b001000, 1'b0);  // jr
    step(6'b000000, 6'b100011, 1'b0);  // subu
    step(6'b100011, 6'b100011, 1'b0);  // lw with subu func
    step(6'b101011, 6'b111111, 1'b0);  // sw
    step(6'b000011, 6'b000000, 1'b0);  // jal
    step(6'b000010, 6'b100001, 1'b0);  // j
    step(6'b000100, 6'b001000, 1'b0);  // beq
    step(6'b001111, 6'b010101, 1'b0);  // lui
    step(6'b000000, 6'b000000, 1'b0);  // nop: illegal, sets sticky
    step(6'b000000, 6'b100001, 1'b0);  // sticky holds on legal op
    step(6'b001101, 6'b000000, 1'b0);
    step(6'b000000, 6'b100001, 1'b1);  // reset clears
    step(6'b000000, 6'b100001, 1'b0);
    step(6'b111111, 6'b000000, 1'b1);  // illegal during reset: reset wins
    step(6'b100011, 6'b000000, 1'b0);

    // full sweep
    for (int oi = 0; oi < 64; oi++) begin
      for (int fi = 0; fi < 64; fi++) begin
        step(oi[5:0], fi[5:0], 1'b0);
      end
    end

    // random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      step(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
           ($urandom_range(0, 15) == 0));
    end

    check_val("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
